// File: rtl/raster_engine.sv
`timescale 1ns/1ps
// raster_engine: command-driven framebuffer rasterizer.
// A CPU command (FILL, POINT, filled RECT, Bresenham LINE) is latched. After one
// SETUP cycle the engine emits one framebuffer pixel per clock.
// Pixels outside the framebuffer are clipped. A clipped pixel still uses its
// cycle, but its write strobe stays low.
//
// Request handshake: execute_request is a one-cycle start strobe. It is only
// honoured when busy is low (state IDLE). At that edge every command input is
// latched. While busy is high the strobe and the command inputs are ignored, and
// no request is queued. busy drops on the edge that finishes the operation, so
// a new request is accepted in the first cycle busy reads 0.
module raster_engine #(
   parameter int unsigned FB_WIDTH  = 214,
   parameter int unsigned FB_HEIGHT = 160,
   parameter int unsigned COORD_W   = 8,
   parameter int unsigned COLOUR_W  = 3,
   parameter int unsigned ADDR_W    = 16
) (
   input  logic                clk,
   input  logic                rst_async,
   input  logic [7:0]          command,
   input  logic [COORD_W-1:0]  x0,
   input  logic [COORD_W-1:0]  y0,
   input  logic [COORD_W-1:0]  x1,
   input  logic [COORD_W-1:0]  y1,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                execute_request,
   output logic                busy,
   output logic                cmd_error,
   output logic [ADDR_W-1:0]   fb_addr,
   output logic                fb_write_en,
   output logic [COLOUR_W-1:0] fb_pixel,
   output logic [1:0]          o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_DRAW  = 2'd2
   } state_t;

   localparam logic [7:0] CMD_NOP   = 8'd0;
   localparam logic [7:0] CMD_FILL  = 8'd1;
   localparam logic [7:0] CMD_POINT = 8'd2;
   localparam logic [7:0] CMD_RECT  = 8'd3;
   localparam logic [7:0] CMD_LINE  = 8'd4;

   localparam logic [ADDR_W-1:0]  C_W         = ADDR_W'(FB_WIDTH);
   localparam logic [ADDR_W-1:0]  C_ONE_A     = ADDR_W'(1);
   localparam logic [COORD_W-1:0] C_ONE_C     = COORD_W'(1);
   localparam logic [ADDR_W-1:0]  C_FILL_LAST = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

   // A pixel is clipped when it lies outside the framebuffer.
   function automatic logic f_clip(input logic [COORD_W-1:0] px,
                                   input logic [COORD_W-1:0] py);
      return (32'(px) >= FB_WIDTH) || (32'(py) >= FB_HEIGHT);
   endfunction

   // FSM state
   state_t r_state;
   state_t w_state_nxt;

   // Latched command
   logic [7:0]          r_cmd;
   logic [COORD_W-1:0]  r_x0, r_y0, r_x1, r_y1;
   logic [COLOUR_W-1:0] r_colour;

   // Walker state and registered outputs
   logic [COORD_W-1:0]        r_x, r_y;
   logic [ADDR_W-1:0]         r_addr, r_row;
   logic signed [COORD_W+1:0] r_err;
   logic                      r_busy, r_cerr, r_we;
   logic [COLOUR_W-1:0]       r_pix;

   // Next values of walker and outputs
   logic [COORD_W-1:0]        w_x_nxt, w_y_nxt;
   logic [ADDR_W-1:0]         w_addr_nxt, w_row_nxt;
   logic signed [COORD_W+1:0] w_err_nxt;
   logic                      w_busy_nxt, w_cerr_nxt, w_we_nxt;
   logic [COLOUR_W-1:0]       w_pix_nxt;

   // Command decode
   logic w_accept;
   logic w_is_fill, w_is_point, w_is_rect, w_is_line, w_draws, w_illegal;

   // Geometry derived from the latched coordinates
   logic [COORD_W-1:0]        w_xmin, w_xmax, w_ymin, w_ymax;
   logic [COORD_W-1:0]        w_dx, w_dy;
   logic                      w_sx_pos, w_sy_pos;
   logic [COORD_W-1:0]        w_start_x, w_start_y;
   logic [ADDR_W-1:0]         w_start_addr;
   logic signed [COORD_W+1:0] w_dx_e, w_dy_e, w_err_init;
   logic signed [COORD_W+2:0] w_dx_w, w_dy_w, w_e2;
   logic                      w_step_x, w_step_y;
   logic                      w_last;

   assign w_accept   = (r_state == S_IDLE) && execute_request;
   assign w_is_fill  = (r_cmd == CMD_FILL);
   assign w_is_point = (r_cmd == CMD_POINT);
   assign w_is_rect  = (r_cmd == CMD_RECT);
   assign w_is_line  = (r_cmd == CMD_LINE);
   assign w_draws    = w_is_fill | w_is_point | w_is_rect | w_is_line;
   assign w_illegal  = (r_cmd > CMD_LINE);

   assign w_xmin = (r_x0 <= r_x1) ? r_x0 : r_x1;
   assign w_xmax = (r_x0 <= r_x1) ? r_x1 : r_x0;
   assign w_ymin = (r_y0 <= r_y1) ? r_y0 : r_y1;
   assign w_ymax = (r_y0 <= r_y1) ? r_y1 : r_y0;

   assign w_sx_pos = (r_x1 >= r_x0);
   assign w_sy_pos = (r_y1 >= r_y0);
   assign w_dx     = w_sx_pos ? (r_x1 - r_x0) : (r_x0 - r_x1);
   assign w_dy     = w_sy_pos ? (r_y1 - r_y0) : (r_y0 - r_y1);

   // The only multiply sits on the setup path. The per-pixel path is add/sub only.
   assign w_start_x    = w_is_rect ? w_xmin : r_x0;
   assign w_start_y    = w_is_rect ? w_ymin : r_y0;
   assign w_start_addr = ADDR_W'(w_start_y) * C_W + ADDR_W'(w_start_x);

   // Bresenham terms. err has two guard bits, and e2 = 2*err has one more.
   assign w_dx_e     = $signed({2'b00, w_dx});
   assign w_dy_e     = $signed({2'b00, w_dy});
   assign w_dx_w     = $signed({3'b000, w_dx});
   assign w_dy_w     = $signed({3'b000, w_dy});
   assign w_err_init = w_dx_e - w_dy_e;
   assign w_e2       = $signed({r_err, 1'b0});
   assign w_step_x   = (w_e2 >= -w_dy_w);
   assign w_step_y   = (w_e2 <= w_dx_w);

   // The current pixel on the outputs is the final one of the operation.
   assign w_last = w_is_fill ? (r_addr == C_FILL_LAST) :
                   w_is_rect ? ((r_x == w_xmax) && (r_y == w_ymax)) :
                   w_is_line ? ((r_x == r_x1) && (r_y == r_y1)) :
                   1'b1;

   // State register; an asynchronous reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state logic: IDLE -> SETUP -> DRAW -> IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (execute_request) w_state_nxt = S_SETUP;
         S_SETUP: w_state_nxt = w_draws ? S_DRAW : S_IDLE;
         S_DRAW:  if (w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/walker next values: preload in SETUP, then step one pixel per DRAW cycle.
   always_comb begin
      w_busy_nxt = r_busy;
      w_cerr_nxt = 1'b0;
      w_we_nxt   = 1'b0;
      w_pix_nxt  = r_pix;
      w_x_nxt    = r_x;
      w_y_nxt    = r_y;
      w_addr_nxt = r_addr;
      w_row_nxt  = r_row;
      w_err_nxt  = r_err;
      case (r_state)
         S_IDLE: begin
            if (execute_request) w_busy_nxt = 1'b1;
         end
         S_SETUP: begin
            if (!w_draws) begin
               w_busy_nxt = 1'b0;
               w_cerr_nxt = w_illegal;
            end else begin
               w_x_nxt   = w_start_x;
               w_y_nxt   = w_start_y;
               w_pix_nxt = r_colour;
               w_err_nxt = w_err_init;
               if (w_is_fill) begin
                  w_addr_nxt = '0;
                  w_row_nxt  = '0;
                  w_we_nxt   = 1'b1;
               end else begin
                  w_addr_nxt = w_start_addr;
                  w_row_nxt  = w_start_addr;
                  w_we_nxt   = !f_clip(w_start_x, w_start_y);
               end
            end
         end
         S_DRAW: begin
            if (w_last) begin
               w_busy_nxt = 1'b0;
            end else if (w_is_fill) begin
               w_addr_nxt = r_addr + C_ONE_A;
               w_we_nxt   = 1'b1;
            end else if (w_is_rect) begin
               if (r_x == w_xmax) begin
                  w_x_nxt    = w_xmin;
                  w_y_nxt    = r_y + C_ONE_C;
                  w_row_nxt  = r_row + C_W;
                  w_addr_nxt = r_row + C_W;
               end else begin
                  w_x_nxt    = r_x + C_ONE_C;
                  w_addr_nxt = r_addr + C_ONE_A;
               end
               w_we_nxt = !f_clip(w_x_nxt, w_y_nxt);
            end else begin
               // Only LINE can reach here; POINT always ends on its first pixel.
               w_err_nxt = r_err - (w_step_x ? w_dy_e : '0) + (w_step_y ? w_dx_e : '0);
               if (w_step_x) begin
                  w_x_nxt    = w_sx_pos ? (r_x + C_ONE_C) : (r_x - C_ONE_C);
                  w_addr_nxt = w_sx_pos ? (w_addr_nxt + C_ONE_A) : (w_addr_nxt - C_ONE_A);
               end
               if (w_step_y) begin
                  w_y_nxt    = w_sy_pos ? (r_y + C_ONE_C) : (r_y - C_ONE_C);
                  w_addr_nxt = w_sy_pos ? (w_addr_nxt + C_W) : (w_addr_nxt - C_W);
               end
               w_we_nxt = !f_clip(w_x_nxt, w_y_nxt);
            end
         end
         default: w_busy_nxt = 1'b0;
      endcase
   end

   // Registered outputs and walker state.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_busy <= 1'b0;
         r_cerr <= 1'b0;
         r_we   <= 1'b0;
         r_pix  <= '0;
         r_addr <= '0;
         r_row  <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_err  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cerr <= w_cerr_nxt;
         r_we   <= w_we_nxt;
         r_pix  <= w_pix_nxt;
         r_addr <= w_addr_nxt;
         r_row  <= w_row_nxt;
         r_x    <= w_x_nxt;
         r_y    <= w_y_nxt;
         r_err  <= w_err_nxt;
      end
   end

   // Command latch: capture every command input when a request is accepted.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_cmd    <= CMD_NOP;
         r_x0     <= '0;
         r_y0     <= '0;
         r_x1     <= '0;
         r_y1     <= '0;
         r_colour <= '0;
      end else if (w_accept) begin
         r_cmd    <= command;
         r_x0     <= x0;
         r_y0     <= y0;
         r_x1     <= x1;
         r_y1     <= y1;
         r_colour <= colour;
      end
   end

   assign busy        = r_busy;
   assign cmd_error   = r_cerr;
   assign fb_addr     = r_addr;
   assign fb_write_en = r_we;
   assign fb_pixel    = r_pix;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_raster_engine.sv
`timescale 1ns/1ps
// Directed bench for raster_engine using the default 214x160 geometry.
module tb_raster_engine;

   logic        clk = 1'b0;
   logic        rst_async = 1'b1;
   logic [7:0]  command = 8'd0;
   logic [7:0]  x0 = 8'd0, y0 = 8'd0, x1 = 8'd0, y1 = 8'd0;
   logic [2:0]  colour = 3'd0;
   logic        execute_request = 1'b0;
   logic        busy, cmd_error, fb_write_en;
   logic [15:0] fb_addr;
   logic [2:0]  fb_pixel;
   logic [1:0]  dbg_state;

   int n_total = 0;
   int n_bad   = 0;
   int n_cerr  = 0;
   int busy_cnt, first_w, done;

   logic [15:0] got_q[$];
   logic [2:0]  gotp_q[$];
   logic [15:0] exp_q[$];

   raster_engine dut (
      .clk             (clk),
      .rst_async       (rst_async),
      .command         (command),
      .x0              (x0),
      .y0              (y0),
      .x1              (x1),
      .y1              (y1),
      .colour          (colour),
      .execute_request (execute_request),
      .busy            (busy),
      .cmd_error       (cmd_error),
      .fb_addr         (fb_addr),
      .fb_write_en     (fb_write_en),
      .fb_pixel        (fb_pixel),
      .o_dbg_state     (dbg_state)
   );

   // 50 MHz clock
   always #10 clk = ~clk;

   // Write and error monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (fb_write_en) begin
         got_q.push_back(fb_addr);
         gotp_q.push_back(fb_pixel);
      end
      if (cmd_error) n_cerr++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one request and count the busy cycles. At busy cycle strobe_at
   // (0 = never), pulse a stray POINT request.
   task automatic run_op(input logic [7:0] cmd, input logic [7:0] ax0, input logic [7:0] ay0,
                         input logic [7:0] ax1, input logic [7:0] ay1, input logic [2:0] col,
                         input int strobe_at);
      @(negedge clk);
      got_q.delete();
      gotp_q.delete();
      n_cerr = 0;
      command = cmd; x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; colour = col;
      execute_request = 1'b1;
      busy_cnt = 0;
      first_w  = 0;
      done     = 0;
      for (int i = 0; i < 40000; i++) begin
         @(negedge clk);
         execute_request = 1'b0;
         if (!busy) begin
            done = 1;
            break;
         end
         busy_cnt++;
         if (fb_write_en && first_w == 0) first_w = busy_cnt;
         if (busy_cnt == strobe_at) begin
            command = 8'd2; x0 = 8'd9; y0 = 8'd9; execute_request = 1'b1;
         end
      end
      chk("op_done", done, 1);
      @(negedge clk);
   endtask

   task automatic cmp_writes(input string tag, input logic [2:0] pix);
      chk({tag, "_nwr"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), got_q[i], exp_q[i]);
         chk($sformatf("%s_pix%0d", tag, i), gotp_q[i], pix);
      end
      exp_q.delete();
   endtask

   initial begin
      int n_gap, n_badpix, hit;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_error", cmd_error, 0);
      chk("rst_we", fb_write_en, 0);
      chk("rst_addr", fb_addr, 0);
      chk("rst_pix", fb_pixel, 0);
      chk("rst_state", dbg_state, 0);
      rst_async = 1'b0;
      repeat (2) @(negedge clk);

      // POINT (5,2) colour 3
      run_op(8'd2, 8'd5, 8'd2, 8'd0, 8'd0, 3'd3, 0);
      chk("point_busy", busy_cnt, 2);
      chk("point_write_cycle", first_w, 2);
      chk("point_we_after", fb_write_en, 0);
      exp_q.push_back(16'd433);
      cmp_writes("point", 3'd3);

      // RECT (3,1)-(1,0) colour 5
      run_op(8'd3, 8'd3, 8'd1, 8'd1, 8'd0, 3'd5, 0);
      chk("rect_busy", busy_cnt, 7);
      chk("rect_first_write", first_w, 2);
      exp_q = '{16'd1, 16'd2, 16'd3, 16'd215, 16'd216, 16'd217};
      cmp_writes("rect", 3'd5);

      // LINE (0,0)-(3,1) colour 4
      run_op(8'd4, 8'd0, 8'd0, 8'd3, 8'd1, 3'd4, 0);
      chk("line_busy", busy_cnt, 5);
      exp_q = '{16'd0, 16'd1, 16'd216, 16'd217};
      cmp_writes("line", 3'd4);

      // Degenerate LINE (2,2)-(2,2)
      run_op(8'd4, 8'd2, 8'd2, 8'd2, 8'd2, 3'd6, 0);
      chk("line_deg_busy", busy_cnt, 2);
      exp_q.push_back(16'd430);
      cmp_writes("line_deg", 3'd6);

      // Steep LINE with negative x step: (3,0)-(1,4)
      run_op(8'd4, 8'd3, 8'd0, 8'd1, 8'd4, 3'd1, 0);
      chk("line_steep_busy", busy_cnt, 6);
      exp_q = '{16'd3, 16'd216, 16'd430, 16'd643, 16'd857};
      cmp_writes("line_steep", 3'd1);

      // POINT (214,0): clipped, so no write, but the pixel cycle is still spent
      run_op(8'd2, 8'd214, 8'd0, 8'd0, 8'd0, 3'd2, 0);
      chk("clip_busy", busy_cnt, 2);
      chk("clip_nwr", got_q.size(), 0);

      // Illegal command 9
      run_op(8'd9, 8'd1, 8'd1, 8'd1, 8'd1, 3'd1, 0);
      chk("illegal_busy", busy_cnt, 1);
      chk("illegal_err_pulses", n_cerr, 1);
      chk("illegal_nwr", got_q.size(), 0);
      chk("illegal_err_after", cmd_error, 0);

      // NOP
      run_op(8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 3'd1, 0);
      chk("nop_busy", busy_cnt, 1);
      chk("nop_err_pulses", n_cerr, 0);
      chk("nop_nwr", got_q.size(), 0);

      // RECT straddling the bottom-right corner: (212,159)-(215,160)
      run_op(8'd3, 8'd215, 8'd160, 8'd212, 8'd159, 3'd2, 0);
      chk("rect_clip_busy", busy_cnt, 9);
      exp_q = '{16'd34238, 16'd34239};
      cmp_writes("rect_clip", 3'd2);

      // FILL colour 7 with a stray strobe at busy cycle 50
      run_op(8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 3'd7, 50);
      chk("fill_busy", busy_cnt, 34241);
      chk("fill_nwr", got_q.size(), 34240);
      n_gap = 0;
      n_badpix = 0;
      foreach (got_q[i]) begin
         if (got_q[i] !== 16'(i)) n_gap++;
         if (gotp_q[i] !== 3'd7) n_badpix++;
      end
      chk("fill_contig", n_gap, 0);
      chk("fill_pix", n_badpix, 0);
      chk("fill_no_requeue", busy, 0);

      // Reset in the middle of a FILL, at address 100
      @(negedge clk);
      command = 8'd1; colour = 3'd6; execute_request = 1'b1;
      @(negedge clk);
      execute_request = 1'b0;
      hit = 0;
      for (int i = 0; i < 400; i++) begin
         if (fb_write_en && fb_addr == 16'd100) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      chk("midrst_reach100", hit, 1);
      rst_async = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_we", fb_write_en, 0);
      chk("midrst_addr", fb_addr, 0);
      @(negedge clk);
      rst_async = 1'b0;
      got_q.delete();
      gotp_q.delete();
      repeat (5) @(negedge clk);
      chk("midrst_no_writes", got_q.size(), 0);
      chk("midrst_idle", busy, 0);

      // POINT (0,0) after the reset
      run_op(8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 3'd2, 0);
      chk("post_rst_busy", busy_cnt, 2);
      exp_q.push_back(16'd0);
      cmp_writes("post_rst", 3'd2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
